// File: rtl/demux_pkg.sv
// Shared constants and slot-state type for the two-stream demultiplexer.
package demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with a 2-state EMPTY/FULL FSM and valid/data outputs.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             drain_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end
        case (state_q)
            SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
            SLOT_FULL:  if (!load_i && drain_i) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the data register is reset too so
    // outputs read 0 after reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux_two_stream.sv
// 1-to-2 registered stream demultiplexer with per-output word counters.
// Counters are built only when DEMUX_TWO_STREAM_CNT_EN is defined; otherwise cnt0/cnt1 read 0.
module demux_two_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic accept;
    logic load0, load1;

    // A slot can take a word if it is empty or its current word leaves this cycle.
    assign in_ready = in_sel ? (!out1_valid || out1_ready)
                             : (!out0_valid || out0_ready);
    assign accept   = in_valid && in_ready;
    assign load0    = accept && !in_sel;
    assign load1    = accept &&  in_sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load0),
        .load_data_i (in_data),
        .drain_i     (out0_ready),
        .valid_o     (out0_valid),
        .data_o      (out0_data)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load1),
        .load_data_i (in_data),
        .drain_i     (out1_ready),
        .valid_o     (out1_valid),
        .data_o      (out1_data)
    );

`ifdef DEMUX_TWO_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q + CNT_W'(load0);
        cnt1_d = cnt1_q + CNT_W'(load1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux_two_stream.sv
// Scoreboard bench for demux_two_stream: the driver queues expected words, a monitor checks outputs.
module tb_demux_two_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out0_data, out1_data;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [15:0] cnt0, cnt1;

    logic        in_ready_w;
    logic [7:0]  out0_data_w, out1_data_w;
    logic        out0_valid_w, out1_valid_w;
    logic [1:0]  cnt0_w, cnt1_w;

    int tests = 0;
    int fails = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         cnt0_m = 0;
    int         cnt1_m = 0;

    always #5 clk = ~clk;

    demux_two_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-counter copy driven by the same stimulus, used for the wrap check.
    demux_two_stream #(.WIDTH(8), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready_w),
        .out0_data(out0_data_w), .out0_valid(out0_valid_w), .out0_ready(out0_ready),
        .out1_data(out1_data_w), .out1_valid(out1_valid_w), .out1_ready(out1_ready),
        .cnt0(cnt0_w), .cnt1(cnt1_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n, input int w);
`ifdef DEMUX_TWO_STREAM_CNT_EN
        return (w == 2) ? 32'(n % 4) : 32'(n % 65536);
`else
        return 32'(0 * n * w);
`endif
    endfunction

    task automatic check_cnts(input string tag);
        check({tag, "_cnt0"}, 32'(cnt0), exp_cnt(cnt0_m, 16));
        check({tag, "_cnt1"}, 32'(cnt1), exp_cnt(cnt1_m, 16));
    endtask

    task automatic push_exp(input logic [7:0] d, input logic s);
        if (s) begin q1.push_back(d); cnt1_m++; end
        else   begin q0.push_back(d); cnt0_m++; end
    endtask

    // Offer one word; returns the number of stalled cycles before it was taken.
    task automatic send(input logic [7:0] d, input logic s, output int waits);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(d, s);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            waits++;
            if (waits > 50) begin
                check("send_timeout", 32'(waits), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        cnt0_m = 0;
        cnt1_m = 0;
    endtask

    // Monitor: any valid output must match the oldest expected word for that port.
    always @(negedge clk) begin
        if (!rst) begin
            if (out0_valid) begin
                check("out0_pending", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    check("out0_data", 32'(out0_data), 32'(q0[0]));
                    if (out0_ready) void'(q0.pop_front());
                end
            end
            if (out1_valid) begin
                check("out1_pending", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    check("out1_data", 32'(out1_data), 32'(q1[0]));
                    if (out1_ready) void'(q1.pop_front());
                end
            end
        end
    end

    // Producer rule: a stalled word must hold its data and select.
    logic       pv = 1'b0;
    logic       ps = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge clk) begin
        if (!rst && pv) begin
            check("producer_hold", 32'({in_valid, in_sel, in_data}), 32'({1'b1, ps, pd}));
        end
        pv = in_valid && !in_ready;
        ps = in_sel;
        pd = in_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;

        // Reset and idle
        #12;
        check("rst_out0_valid", 32'(out0_valid), 0);
        check("rst_out1_valid", 32'(out1_valid), 0);
        check("rst_out0_data",  32'(out0_data),  0);
        check("rst_out1_data",  32'(out1_data),  0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready_sel0", 32'(in_ready), 1);
        in_sel = 1'b1; #1;
        check("idle_in_ready_sel1", 32'(in_ready), 1);
        check_cnts("idle");
        @(posedge clk); #1;

        // Single word to out0, latency one cycle then drains
        send(8'hA5, 1'b0, w);
        check("a5_out0_valid", 32'(out0_valid), 1);
        check("a5_out0_data",  32'(out0_data), 32'h A5);
        @(posedge clk); #1;
        check("a5_out0_gone", 32'(out0_valid), 0);
        check_cnts("a5");

        // Blocked out1: second word stalls, then replaces in the drain cycle
        out1_ready = 1'b0;
        send(8'h11, 1'b1, w);
        in_data = 8'h22; in_sel = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready_a", 32'(in_ready), 0);
        check("stall_out1_hold_a", 32'(out1_data), 32'h11);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_in_ready_b", 32'(in_ready), 0);
        check("stall_out1_hold_b", 32'(out1_data), 32'h11);
        @(posedge clk); #1 out1_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 1);
        push_exp(8'h22, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; out1_ready = 1'b0;
        check("replace_out1_valid", 32'(out1_valid), 1);
        check("replace_out1_data",  32'(out1_data), 32'h22);
        check_cnts("replace");

        // out1 still blocked; a word for out0 passes immediately
        send(8'h33, 1'b0, w);
        check("bypass_waits", 32'(w), 0);
        check("bypass_out0_data", 32'(out0_data), 32'h33);
        check("bypass_out1_valid", 32'(out1_valid), 1);
        check("bypass_out1_data", 32'(out1_data), 32'h22);
        out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean start, then 10 alternating back-to-back words
        rst = 1'b1; #3; clear_model();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            logic       s;
            d = 8'h40 + 8'(i);
            s = (i % 2) == 1;
            send(d, s, w);
            check("b2b_waits", 32'(w), 0);
            if (s) check("b2b_out1_data", 32'(out1_data), 32'(d));
            else   check("b2b_out0_data", 32'(out0_data), 32'(d));
            if (!s) check("wrap_cnt0_w", 32'(cnt0_w), exp_cnt(cnt0_m, 2));
        end
        check_cnts("b2b");
        @(posedge clk); #1;

        // Reset while both slots are full
        out0_ready = 1'b0; out1_ready = 1'b0;
        send(8'h55, 1'b0, w);
        send(8'h66, 1'b1, w);
        check("full_both", 32'({out0_valid, out1_valid}), 32'b11);
        #2 rst = 1'b1;
        #1;
        check("arst_out0_valid", 32'(out0_valid), 0);
        check("arst_out1_valid", 32'(out1_valid), 0);
        check("arst_out0_data",  32'(out0_data),  0);
        check("arst_cnt0", 32'(cnt0), 0);
        check("arst_cnt1", 32'(cnt1), 0);
        clear_model();
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valids", 32'({out0_valid, out1_valid}), 0);
        check("end_q0_empty", 32'(q0.size()), 0);
        check("end_q1_empty", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
